mips_alu_decode: RTL and testbench
==================================

# mips_alu_decode

Registered MIPS instruction decoder that drives the control side of the 32-bit ALU. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes opcode/funct into the 4-bit ALUC code. It also produces operand-select controls, the extended immediate, the shift amount and the destination register. Results are presented one cycle later behind a registered output stage with backpressure. A saturating counter tracks illegal encodings.

## Interface
- No parameters; all widths are fixed by the MIPS encoding.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  INSTR is valid.
- IN_READY  out  1  decoder can accept this cycle.
- INSTR  in  32  MIPS instruction word.
- OUT_VALID  out  1  decoded fields are valid.
- OUT_READY  in  1  consumer accepts decoded fields.
- ALUC  out  4  ALU opcode: ADD x000, SUB x100, AND x001, OR x101, XOR x010, LUI x110, SLL 0011, SRL 0111, SRA 1111. Don't-care x bits are driven 0.
- SHIFT  out  1  ALU operand A is taken from SHAMT instead of rs.
- ALUIMM  out  1  ALU operand B is taken from IMM32 instead of rt.
- SHAMT  out  5  INSTR[10:6].
- IMM32  out  32  INSTR[15:0], sign-extended if SEXT, else zero-extended.
- SEXT  out  1  immediate is sign-extended.
- DEST  out  5  write register: rt (INSTR[20:16]) for I-type, rd (INSTR[15:11]) for R-type.
- WREG  out  1  instruction writes the register file.
- ILLEGAL  out  1  encoding is not supported.
- ILL_CNT  out  8  saturating count of accepted illegal instructions.

## Operation
- Transfer occurs when IN_VALID & IN_READY. The decode is computed combinationally from INSTR and captured into the output register on transfer.
- R-type (op 000000): WREG=1, DEST=rd, ALUIMM=0, SEXT=0. Funct decode:
  - 100000 add → 0000
  - 100010 sub → 0100
  - 100100 and → 0001
  - 100101 or → 0101
  - 100110 xor → 0010
  - 000000 sll → 0011, SHIFT=1
  - 000010 srl → 0111, SHIFT=1
  - 000011 sra → 1111, SHIFT=1
- I-type decode, listed as op → ALUC [flags]:
  - addi 001000 → 0000 [ALUIMM SEXT WREG]
  - andi 001100 → 0001 [ALUIMM WREG]
  - ori 001101 → 0101 [ALUIMM WREG]
  - xori 001110 → 0010 [ALUIMM WREG]
  - lui 001111 → 0110 [ALUIMM WREG]
  - lw 100011 → 0000 [ALUIMM SEXT WREG]
  - sw 101011 → 0000 [ALUIMM SEXT]
  - beq 000100 → 0100 [none]
  - bne 000101 → 0100 [none]
  - All I-type instructions have DEST=rt and SHIFT=0.
- Any other op, or an R-type with any other funct: ILLEGAL=1. ALUC, SHIFT, ALUIMM, SEXT and WREG are all 0. DEST, SHAMT and IMM32 are still decoded by field position.
- 0x00000000 decodes as sll $0,$0,0 (a legal no-op) with WREG=1 and DEST=0.
- ILL_CNT increments on each transfer with ILLEGAL decode and saturates at 255, with no wrap.

## Timing
- Latency: 1 cycle. OUT_VALID rises on the edge that performs the transfer.
- IN_READY = !OUT_VALID | OUT_READY (combinational), giving a throughput of 1 instruction per cycle.
- OUT_VALID falls after an output handshake with no new transfer in the same cycle.
- While OUT_VALID & !OUT_READY, all outputs hold stable and IN_READY=0.
- Simultaneous output handshake and input transfer: the output register is replaced with the new decode and OUT_VALID stays 1.
- Reset (async, any time, including mid-stall):
  - OUT_VALID=0 and ILL_CNT=0.
  - All decoded outputs are 0.
  - IN_READY=1 during and after reset.
  - The in-flight instruction is discarded.

## Test plan
- add $3,$1,$2 (0x00221820) with OUT_READY=1 → next cycle OUT_VALID=1, ALUC=0000, DEST=3, WREG=1, ALUIMM=0, SHIFT=0, ILLEGAL=0.
- addi $2,$1,-1 (0x2022FFFF) then andi $2,$1,0xFFFF (0x3022FFFF) back-to-back:
  - first: IMM32=0xFFFFFFFF, SEXT=1, ALUC=0000;
  - second: IMM32=0x0000FFFF, SEXT=0, ALUC=0001;
  - both: DEST=2, ALUIMM=1, WREG=1, outputs on consecutive cycles.
- sra $2,$1,4 (0x00011103) → ALUC=1111, SHIFT=1, SHAMT=4, DEST=2. Also sw (0xAC220004) → ALUC=0000, WREG=0, IMM32=4. Also beq (0x10220003) → ALUC=0100, ALUIMM=0, WREG=0.
- Backpressure: present lui (0x3C021234) with OUT_READY=0 for 3 cycles → outputs are held (ALUC=0110, IMM32=0x00001234) and IN_READY=0. Then raise OUT_READY with a new instruction valid → the new decode appears the next cycle and nothing is lost or duplicated.
- Illegal: op 111111 (0xFC000000) and R-type funct 101010 (0x0022182A) → ILLEGAL=1 and ALUC=0000 for each, ILL_CNT=2. Streaming 300 illegals → ILL_CNT=255.
- Reset mid-stall: assert RST asynchronously (between clock edges) while OUT_VALID=1 and OUT_READY=0 → OUT_VALID=0, ILL_CNT=0 and IN_READY=1 immediately. After RST deasserts, the first new instruction decodes with 1-cycle latency.

Source files
------------

// File: rtl/mips_alu_decode.sv
// Registered MIPS instruction decoder for the ALU control path.
// One instruction per cycle in over valid/ready; decoded fields leave through a single output register.
module mips_alu_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [3:0]  ALUC,
  output logic        SHIFT,
  output logic        ALUIMM,
  output logic [4:0]  SHAMT,
  output logic [31:0] IMM32,
  output logic        SEXT,
  output logic [4:0]  DEST,
  output logic        WREG,
  output logic        ILLEGAL,
  output logic [7:0]  ILL_CNT
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef struct packed {
    logic [3:0]  aluc;
    logic        shift;
    logic        aluimm;
    logic        sext;
    logic        wreg;
    logic        illegal;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] imm32;
  } dec_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_rs;
  dec_t       dec;
  dec_t       dec_d, dec_q;
  logic       out_valid_d, out_valid_q;
  logic [7:0] ill_cnt_d, ill_cnt_q;
  logic       xfer;

  assign op        = INSTR[31:26];
  assign funct     = INSTR[5:0];
  assign unused_rs = ^INSTR[25:21];

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
    dec         = '0;
    dec.shamt   = INSTR[10:6];
    dec.dest    = INSTR[20:16];
    case (op)
      OP_RTYPE: begin
        dec.dest = INSTR[15:11];
        dec.wreg = 1'b1;
        case (funct)
          FN_ADD:  dec.aluc = ALUC_ADD;
          FN_SUB:  dec.aluc = ALUC_SUB;
          FN_AND:  dec.aluc = ALUC_AND;
          FN_OR:   dec.aluc = ALUC_OR;
          FN_XOR:  dec.aluc = ALUC_XOR;
          FN_SLL:  begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; end
          FN_SRL:  begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; end
          FN_SRA:  begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; end
          default: begin dec.wreg = 1'b0; dec.illegal = 1'b1; end
        endcase
      end
      OP_ADDI, OP_LW: begin
        dec.aluc = ALUC_ADD; dec.aluimm = 1'b1; dec.sext = 1'b1; dec.wreg = 1'b1;
      end
      OP_SW: begin
        dec.aluc = ALUC_ADD; dec.aluimm = 1'b1; dec.sext = 1'b1;
      end
      OP_ANDI: begin dec.aluc = ALUC_AND; dec.aluimm = 1'b1; dec.wreg = 1'b1; end
      OP_ORI:  begin dec.aluc = ALUC_OR;  dec.aluimm = 1'b1; dec.wreg = 1'b1; end
      OP_XORI: begin dec.aluc = ALUC_XOR; dec.aluimm = 1'b1; dec.wreg = 1'b1; end
      OP_LUI:  begin dec.aluc = ALUC_LUI; dec.aluimm = 1'b1; dec.wreg = 1'b1; end
      OP_BEQ, OP_BNE: dec.aluc = ALUC_SUB;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm32 = dec.sext ? {{16{INSTR[15]}}, INSTR[15:0]} : {16'h0000, INSTR[15:0]};
  end

  // The output register may be overwritten in the same cycle it is drained.
  assign IN_READY = !out_valid_q || OUT_READY;
  assign xfer     = IN_VALID && IN_READY;

  always_comb begin
    dec_d       = dec_q;
    out_valid_d = out_valid_q;
    ill_cnt_d   = ill_cnt_q;
    if (xfer) begin
      dec_d       = dec;
      out_valid_d = 1'b1;
      if (dec.illegal && ill_cnt_q != 8'hFF)
        ill_cnt_d = ill_cnt_q + 8'd1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
      ill_cnt_q   <= 8'h00;
    end else begin
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ALUC      = dec_q.aluc;
  assign SHIFT     = dec_q.shift;
  assign ALUIMM    = dec_q.aluimm;
  assign SEXT      = dec_q.sext;
  assign WREG      = dec_q.wreg;
  assign ILLEGAL   = dec_q.illegal;
  assign SHAMT     = dec_q.shamt;
  assign DEST      = dec_q.dest;
  assign IMM32     = dec_q.imm32;
  assign ILL_CNT   = ill_cnt_q;

endmodule

// File: tb/tb_mips_alu_decode.sv
// Directed bench for mips_alu_decode: expected decodes are queued on each input transfer
// and compared against the output register when it presents them.
module tb_mips_alu_decode;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  ALUC;
  logic        SHIFT;
  logic        ALUIMM;
  logic [4:0]  SHAMT;
  logic [31:0] IMM32;
  logic        SEXT;
  logic [4:0]  DEST;
  logic        WREG;
  logic        ILLEGAL;
  logic [7:0]  ILL_CNT;

  mips_alu_decode dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INSTR(INSTR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ALUC(ALUC), .SHIFT(SHIFT),
    .ALUIMM(ALUIMM), .SHAMT(SHAMT), .IMM32(IMM32), .SEXT(SEXT), .DEST(DEST),
    .WREG(WREG), .ILLEGAL(ILLEGAL), .ILL_CNT(ILL_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  aluc;
    logic        shift;
    logic        aluimm;
    logic        sext;
    logic        wreg;
    logic        illegal;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] imm32;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t mk(logic [3:0] aluc, logic shift, logic aluimm, logic sext,
                              logic wreg, logic illegal, logic [4:0] shamt,
                              logic [4:0] dest, logic [31:0] imm32);
    exp_t e;
    e.aluc = aluc; e.shift = shift; e.aluimm = aluimm; e.sext = sext;
    e.wreg = wreg; e.illegal = illegal; e.shamt = shamt; e.dest = dest; e.imm32 = imm32;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic ordy);
    IN_VALID  = v;
    INSTR     = ins;
    OUT_READY = ordy;
    #1;
  endtask

  // Queue the expected decode only if the current cycle will really transfer.
  task automatic push_if_xfer(exp_t e);
    if (IN_VALID && IN_READY) sb.push_back(e);
  endtask

  task automatic cmp_head(string tag, bit pop);
    exp_t e;
    check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb[0];
    check({tag, ".out_valid"}, OUT_VALID, 1'b1);
    check({tag, ".aluc"},      ALUC,      e.aluc);
    check({tag, ".shift"},     SHIFT,     e.shift);
    check({tag, ".aluimm"},    ALUIMM,    e.aluimm);
    check({tag, ".sext"},      SEXT,      e.sext);
    check({tag, ".wreg"},      WREG,      e.wreg);
    check({tag, ".illegal"},   ILLEGAL,   e.illegal);
    check({tag, ".shamt"},     SHAMT,     e.shamt);
    check({tag, ".dest"},      DEST,      e.dest);
    check({tag, ".imm32"},     IMM32,     e.imm32);
    if (pop) void'(sb.pop_front());
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; INSTR = '0; OUT_READY = 1'b1;
    #12;
    check("rst.in_ready",  IN_READY,  1'b1);
    check("rst.out_valid", OUT_VALID, 1'b0);
    check("rst.ill_cnt",   ILL_CNT,   8'd0);
    check("rst.aluc",      ALUC,      4'd0);
    check("rst.imm32",     IMM32,     32'd0);
    RST = 1'b0;
    tick();

    // add $3,$1,$2
    drive(1'b1, 32'h00221820, 1'b1);
    push_if_xfer(mk(4'b0000, 0, 0, 0, 1, 0, 5'd0, 5'd3, 32'h00001820));
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("add", 1'b1);
    tick();
    check("add.drain_valid", OUT_VALID, 1'b0);

    // addi then andi back-to-back
    drive(1'b1, 32'h2022FFFF, 1'b1);
    push_if_xfer(mk(4'b0000, 0, 1, 1, 1, 0, 5'd31, 5'd2, 32'hFFFFFFFF));
    tick();
    drive(1'b1, 32'h3022FFFF, 1'b1);
    push_if_xfer(mk(4'b0001, 0, 1, 0, 1, 0, 5'd31, 5'd2, 32'h0000FFFF));
    cmp_head("addi", 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("andi", 1'b1);

    // sra, sw, beq streamed
    drive(1'b1, 32'h00011103, 1'b1);
    push_if_xfer(mk(4'b1111, 1, 0, 0, 1, 0, 5'd4, 5'd2, 32'h00001103));
    tick();
    drive(1'b1, 32'hAC220004, 1'b1);
    push_if_xfer(mk(4'b0000, 0, 1, 1, 0, 0, 5'd0, 5'd2, 32'h00000004));
    cmp_head("sra", 1'b1);
    tick();
    drive(1'b1, 32'h10220003, 1'b1);
    push_if_xfer(mk(4'b0100, 0, 0, 0, 0, 0, 5'd0, 5'd2, 32'h00000003));
    cmp_head("sw", 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("beq", 1'b1);
    tick();

    // Backpressure: lui held for 3 cycles while xori waits at the input
    drive(1'b1, 32'h3C021234, 1'b0);
    push_if_xfer(mk(4'b0110, 0, 1, 0, 1, 0, 5'd8, 5'd2, 32'h00001234));
    tick();
    drive(1'b1, 32'h38421111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall.in_ready", IN_READY, 1'b0);
      cmp_head("stall.lui", 1'b0);
      tick();
    end
    drive(1'b1, 32'h38421111, 1'b1);
    check("release.in_ready", IN_READY, 1'b1);
    push_if_xfer(mk(4'b0010, 0, 1, 0, 1, 0, 5'd4, 5'd2, 32'h00001111));
    cmp_head("release.lui", 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("xori", 1'b1);
    tick();
    check("release.drained", OUT_VALID, 1'b0);

    // Illegal opcode and illegal funct
    drive(1'b1, 32'hFC000000, 1'b1);
    push_if_xfer(mk(4'b0000, 0, 0, 0, 0, 1, 5'd0, 5'd0, 32'h00000000));
    tick();
    drive(1'b1, 32'h0022182A, 1'b1);
    push_if_xfer(mk(4'b0000, 0, 0, 0, 0, 1, 5'd0, 5'd3, 32'h0000182A));
    cmp_head("ill_op", 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("ill_funct", 1'b1);
    check("ill.cnt2", ILL_CNT, 8'd2);

    // Saturation: 2 + 253 reaches 255, further illegals must not wrap
    drive(1'b1, 32'hFC000000, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 252) check("ill.cnt255", ILL_CNT, 8'd255);
      if (i == 253) check("ill.no_wrap", ILL_CNT, 8'd255);
    end
    check("ill.cnt_final", ILL_CNT, 8'd255);
    drive(1'b0, 32'h0, 1'b1);
    tick();

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 32'h00221820, 1'b0);
    push_if_xfer(mk(4'b0000, 0, 0, 0, 1, 0, 5'd0, 5'd3, 32'h00001820));
    tick();
    drive(1'b0, 32'h0, 1'b0);
    cmp_head("prereset", 1'b0);
    check("prereset.in_ready", IN_READY, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    sb.delete();
    check("mrst.out_valid", OUT_VALID, 1'b0);
    check("mrst.ill_cnt",   ILL_CNT,   8'd0);
    check("mrst.in_ready",  IN_READY,  1'b1);
    check("mrst.wreg",      WREG,      1'b0);
    check("mrst.dest",      DEST,      5'd0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    check("mrst.after_in_ready", IN_READY, 1'b1);
    tick();
    drive(1'b1, 32'h00011103, 1'b1);
    push_if_xfer(mk(4'b1111, 1, 0, 0, 1, 0, 5'd4, 5'd2, 32'h00001103));
    tick();
    drive(1'b0, 32'h0, 1'b1);
    cmp_head("post_rst.sra", 1'b1);
    tick();
    check("post_rst.drained", OUT_VALID, 1'b0);
    check("sb.empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
